operand_stack: RTL

- LIFO operand stack for the multicycle stack CPU.
- Responds to the `push`/`pop` strobes issued by the control unit.
- Supplies the ALU/memory datapath with top-of-stack (TOS) and next-on-stack (NOS).
- Returns the `tos_zero` flag that the control unit uses for conditional jumps.
- Tracks occupancy and latches sticky overflow/underflow errors for debug.

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_regfile.sv | 32 +++
 rtl/operand_stack.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared constants and op encoding for the stack CPU operand stack.
// Imported by the stack register file and the stack control top.
package stack_pkg;

   localparam int STK_WIDTH = 8;
   localparam int STK_DEPTH = 8;

   typedef enum logic [1:0] {
      STK_IDLE,
      STK_PUSH,
      STK_POP,
      STK_REPL
   } stk_op_e;

   function automatic stk_op_e stk_decode(input logic push,
                                          input logic pop);
      stk_op_e op;
      unique case ({push, pop})
         2'b10:   op = STK_PUSH;
         2'b01:   op = STK_POP;
         2'b11:   op = STK_REPL;
         default: op = STK_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stack_regfile.sv
// Operand stack storage: one sync write port, two async read ports.
// Contents are intentionally not reset.
module stack_regfile
   import stack_pkg::*;
#(
   parameter int WIDTH = STK_WIDTH,
   parameter int DEPTH = STK_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   // write the addressed entry on the rising edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack: pointer, op decode, TOS/NOS gating, sticky errors.
// Read path is purely combinational from registered state.
module operand_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = STK_WIDTH,
   parameter int DEPTH = STK_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic             tos_zero,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int AW = $clog2(DEPTH);

   stk_op_e          op;
   logic [CNT_W-1:0] sp;
   logic [CNT_W-1:0] sp_nxt;
   logic [AW-1:0]    tos_addr;
   logic [AW-1:0]    nos_addr;
   logic [AW-1:0]    waddr;
   logic             we;
   logic             ovf_set;
   logic             unf_set;
   logic [WIDTH-1:0] tos_raw;
   logic [WIDTH-1:0] nos_raw;

   assign op       = stk_decode(push, pop);
   assign tos_addr = AW'(sp - CNT_W'(1));
   assign nos_addr = AW'(sp - CNT_W'(2));

   assign empty    = (sp == '0);
   assign full     = (sp == CNT_W'(DEPTH));
   assign count    = sp;
   assign tos      = empty ? '0 : tos_raw;
   assign nos      = (sp < CNT_W'(2)) ? '0 : nos_raw;
   assign tos_zero = (tos == '0);

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (din),
      .raddr_a (tos_addr),
      .rdata_a (tos_raw),
      .raddr_b (nos_addr),
      .rdata_b (nos_raw)
   );

   // next pointer, write strobe and error events for this cycle's op
   always_comb begin
      sp_nxt  = sp;
      we      = 1'b0;
      waddr   = AW'(sp);
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (op)
         STK_PUSH: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               we     = 1'b1;
               sp_nxt = sp + CNT_W'(1);
            end
         end
         STK_POP: begin
            if (empty) begin
               unf_set = 1'b1;
            end else begin
               sp_nxt = sp - CNT_W'(1);
            end
         end
         STK_REPL: begin
            we = 1'b1;
            if (empty) begin
               unf_set = 1'b1;
               sp_nxt  = CNT_W'(1);
            end else begin
               waddr = tos_addr;
            end
         end
         default: ;
      endcase
   end

   // stack pointer register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp <= '0;
      end else begin
         sp <= sp_nxt;
      end
   end

   // sticky error flags; a new error beats a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end

endmodule
